// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
//  ifu_state_e      : fetch sequencer states
//  RESET_PC_DEFAULT : default fetch PC after reset
//  INST_NOP         : canonical NOP (addi x0,x0,0), used as filler
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] INST_NOP         = 32'h0000_0013;

endpackage

// File: rtl/inst_fetch_unit_fetch_buffer.sv
// Single-entry holding register between fetch and decode.
//  clk, rst      : clock, asynchronous active-high reset
//  load_i        : capture data_i/pc_i and raise valid_o
//  data_i, pc_i  : instruction word and its PC
//  ready_i       : downstream consumes the entry this cycle
//  kill_i        : invalidate the entry (redirect)
//  valid_o       : entry valid
//  inst_o, pc_o  : buffered instruction word and PC
module fetch_buffer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [XLEN-1:0] data_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            ready_i,
  input  logic            kill_i,
  output logic            valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] pc_o
);

  logic            valid_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
    end else if (kill_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      inst_q  <= data_i;
      pc_q    <= pc_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues one word read at a time
// to instruction memory and hands the word plus its PC to decode.
//  clk, rst                         : clock, asynchronous active-high reset
//  redirect_valid, redirect_pc      : PC change request from execute
//  imem_req_valid/ready/addr        : memory request channel
//  imem_resp_valid/data             : memory response (single-cycle pulse)
//  inst_valid/ready, inst, inst_pc  : decode handoff channel
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0]  RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned  XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            drop_q, drop_d;
  logic            buf_load, buf_kill;
  logic [XLEN-1:0] redirect_tgt;

  assign redirect_tgt = redirect_pc & ~XLEN'(3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= XLEN'(RESET_PC);
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    drop_d   = drop_q;
    buf_load = 1'b0;
    buf_kill = 1'b0;
    if (redirect_valid) pc_d = redirect_tgt;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // An accepted request that coincides with a redirect is already in
        // flight to the old address, so its response must be discarded.
        if (imem_req_ready) begin
          state_d = WAIT;
          drop_d  = redirect_valid;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          if (redirect_valid || drop_q) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            buf_load = 1'b1;
            state_d  = HOLD;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          buf_kill = 1'b1;
          state_d  = REQ;
        end else if (inst_ready) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = imem_req_valid ? pc_q : '0;

  fetch_buffer #(.XLEN(XLEN)) u_buf (
    .clk     (clk),
    .rst     (rst),
    .load_i  (buf_load),
    .data_i  (imem_resp_data),
    .pc_i    (pc_q),
    .ready_i (inst_ready),
    .kill_i  (buf_kill),
    .valid_o (inst_valid),
    .inst_o  (inst),
    .pc_o    (inst_pc)
  );

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(32'h8000_0000), .XLEN(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc)
  );

  typedef struct {
    int          lat;
    int          hold;
    logic [31:0] data;
    logic [31:0] addr;
    int          exp_wait;
  } vec_t;

  vec_t vecs [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One complete fetch: wait for request, accept, respond after lat cycles,
  // stall decode for hold cycles, then consume.
  task automatic fetch(input int lat, input int hold, input logic [31:0] data,
                       input logic [31:0] addr, input int exp_wait);
    int w = 0;
    while (!imem_req_valid && w < 20) begin
      step();
      w++;
    end
    chk("req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("req_wait_cycles", w, exp_wait);
    chk("req_addr", imem_req_addr, addr);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk("req_dropped_in_wait", {31'b0, imem_req_valid}, 32'd0);
    repeat (lat - 1) step();
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    step();
    imem_resp_valid = 1'b0;
    imem_resp_data  = INST_NOP;
    chk("inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("inst", inst, data);
    chk("inst_pc", inst_pc, addr);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", {31'b0, inst_valid}, 32'd1);
      chk("hold_inst", inst, data);
      chk("hold_pc", inst_pc, addr);
      chk("hold_no_req", {31'b0, imem_req_valid}, 32'd0);
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("consumed_valid", {31'b0, inst_valid}, 32'd0);
    chk("next_req", {31'b0, imem_req_valid}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{lat: 1, hold: 0, data: 32'h0000_0013, addr: 32'h8000_0000, exp_wait: 1};
    vecs[1] = '{lat: 1, hold: 0, data: 32'h00a0_0093, addr: 32'h8000_0004, exp_wait: 0};
    vecs[2] = '{lat: 1, hold: 0, data: 32'h0010_8113, addr: 32'h8000_0008, exp_wait: 0};
    vecs[3] = '{lat: 5, hold: 4, data: 32'hdead_beef, addr: 32'h8000_000C, exp_wait: 0};
    vecs[4] = '{lat: 2, hold: 1, data: 32'h1234_5678, addr: 32'h8000_0010, exp_wait: 0};

    // Reset state
    step();
    step();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      fetch(vecs[i].lat, vecs[i].hold, vecs[i].data, vecs[i].addr, vecs[i].exp_wait);

    // Redirect while waiting; stale response arrives two cycles later
    chk("A_req_addr", imem_req_addr, 32'h8000_0014);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    step();
    redirect_valid = 1'b0;
    chk("A_still_wait", {31'b0, imem_req_valid}, 32'd0);
    step();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hbad0_0001;
    step();
    imem_resp_valid = 1'b0;
    chk("A_resp_dropped", {31'b0, inst_valid}, 32'd0);
    chk("A_new_req", {31'b0, imem_req_valid}, 32'd1);
    chk("A_new_addr", imem_req_addr, 32'h8000_0100);
    fetch(1, 0, 32'h0000_1111, 32'h8000_0100, 0);

    // Redirect in HOLD coinciding with inst_ready
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_2222;
    step();
    imem_resp_valid = 1'b0;
    chk("B_inst_pc", inst_pc, 32'h8000_0104);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    inst_ready     = 1'b1;
    step();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    chk("B_killed", {31'b0, inst_valid}, 32'd0);
    chk("B_req_addr", imem_req_addr, 32'h8000_0200);
    fetch(1, 0, 32'h0000_3333, 32'h8000_0200, 0);

    // Redirect in REQ without accept, low bits masked; then wrap at top
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    chk("C_mask_addr", imem_req_addr, 32'hFFFF_FFFC);
    fetch(1, 0, 32'h0000_4444, 32'hFFFF_FFFC, 0);
    fetch(1, 0, 32'h0000_5555, 32'h0000_0000, 0);

    // Redirect in REQ accepted same cycle -> in-flight response dropped
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    imem_req_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    chk("E_in_wait", {31'b0, imem_req_valid}, 32'd0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hbad0_0002;
    step();
    imem_resp_valid = 1'b0;
    chk("E_dropped", {31'b0, inst_valid}, 32'd0);
    chk("E_req_addr", imem_req_addr, 32'h8000_0300);

    // Reset mid-fetch; stale responses during IDLE and REQ ignored
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("D_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("D_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    step();
    rst = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hbad0_0003;
    step();
    step();
    imem_resp_valid = 1'b0;
    chk("D_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("D_req_addr", imem_req_addr, 32'h8000_0000);
    chk("D_no_inst", {31'b0, inst_valid}, 32'd0);
    fetch(1, 0, 32'h0000_6666, 32'h8000_0000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
